i2s_tx_master: RTL and testbench



---
 rtl/i2s_tx_master.sv | 146 ++++++++++++++
 tb/tb_i2s_tx_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_master.sv
// I2S master transmitter: single-entry sample-pair buffer, MSB-first serialisation
// with the standard one-bit ws lead. All state moves on the falling edge of sck.
module i2s_tx_master #(
  parameter int WIDTH      = 24,
  parameter int FRAME_BITS = 32
) (
  input  logic             i_sck,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_left_in,
  input  logic [WIDTH-1:0] i_right_in,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_ws,
  output logic             o_sd,
  output logic             o_frame_start,
  output logic             o_underrun
);

  // state | meaning
  // IDLE  | stopped; ws=0, sd=0, cnt held at 0
  // RUN   | framing; cnt advances on every falling sck edge
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam int            CW       = $clog2(2 * FRAME_BITS);
  localparam logic [CW-1:0] C_LAST   = CW'(2 * FRAME_BITS - 1);
  localparam logic [CW-1:0] C_WS_SET = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] C_RIGHT  = CW'(FRAME_BITS);

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_buf_full;
  logic [WIDTH-1:0]   r_buf_l;
  logic [WIDTH-1:0]   r_buf_r;
  logic [WIDTH-1:0]   r_sh_l;
  logic [WIDTH-1:0]   r_sh_r;
  logic               r_ws;
  logic               r_sd;
  logic               r_frame_start;
  logic               r_underrun;

  state_t             w_state_nxt;
  logic [CW-1:0]      w_cnt_nxt;
  logic               w_load;
  logic               w_accept;
  logic [WIDTH-1:0]   w_src_l;
  logic [WIDTH-1:0]   w_src_r;
  logic [WIDTH-1:0]   w_sh_l_nxt;
  logic [WIDTH-1:0]   w_sh_r_nxt;
  logic               w_sd_nxt;
  logic               w_ws_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (i_en) begin
          w_state_nxt = S_RUN;
          w_load      = 1'b1;
        end
      end
      S_RUN: begin
        if (r_cnt == C_LAST) begin
          w_cnt_nxt = '0;
          if (i_en) w_load = 1'b1;
          else      w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Shift registers fill with zeros as they shift, so slot padding needs no extra logic.
  always_comb begin
    w_accept = i_in_valid & ~r_buf_full;
    w_src_l  = r_sh_l;
    w_src_r  = r_sh_r;
    if (w_load) begin
      w_src_l = r_buf_full ? r_buf_l : '0;
      w_src_r = r_buf_full ? r_buf_r : '0;
    end
    w_sh_l_nxt = w_src_l;
    w_sh_r_nxt = w_src_r;
    w_sd_nxt   = 1'b0;
    w_ws_nxt   = 1'b0;
    if (w_state_nxt == S_RUN) begin
      if (w_cnt_nxt < C_RIGHT) begin
        w_sd_nxt   = w_src_l[WIDTH-1];
        w_sh_l_nxt = w_src_l << 1;
      end else begin
        w_sd_nxt   = w_src_r[WIDTH-1];
        w_sh_r_nxt = w_src_r << 1;
      end
      if (w_cnt_nxt == C_WS_SET)   w_ws_nxt = 1'b1;
      else if (w_cnt_nxt == C_LAST) w_ws_nxt = 1'b0;
      else                          w_ws_nxt = r_ws;
    end
  end

  always_ff @(negedge i_sck) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_buf_full    <= 1'b0;
      r_buf_l       <= '0;
      r_buf_r       <= '0;
      r_sh_l        <= '0;
      r_sh_r        <= '0;
      r_ws          <= 1'b0;
      r_sd          <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_sh_l        <= w_sh_l_nxt;
      r_sh_r        <= w_sh_r_nxt;
      r_ws          <= w_ws_nxt;
      r_sd          <= w_sd_nxt;
      r_frame_start <= w_load;
      r_underrun    <= w_load & ~r_buf_full;
      if (w_load && r_buf_full) begin
        r_buf_full <= 1'b0;
      end else if (w_accept) begin
        r_buf_full <= 1'b1;
        r_buf_l    <= i_left_in;
        r_buf_r    <= i_right_in;
      end
    end
  end

  assign o_in_ready    = ~r_buf_full;
  assign o_ws          = r_ws;
  assign o_sd          = r_sd;
  assign o_frame_start = r_frame_start;
  assign o_underrun    = r_underrun;

endmodule

// File: tb/tb_i2s_tx_master.sv
// Scoreboard bench: a frame-level reference model queues expected frames at each load,
// a monitor pops them on frame_start and checks every serial bit, ws and in_ready.
module tb_i2s_tx_master;
  localparam int W    = 8;
  localparam int FB   = 8;
  localparam int LAST = 2 * FB - 1;
  localparam int DW   = 24;
  localparam int DFB  = 32;

  logic sck = 1'b0;
  always #5 sck = ~sck;

  logic         reset, en, in_valid, in_ready, ws, sd, frame_start, underrun;
  logic [W-1:0] left_in, right_in;

  logic          b_reset, b_en, b_valid, b_ready, b_ws, b_sd, b_fs, b_und;
  logic [DW-1:0] b_left, b_right;

  i2s_tx_master #(.WIDTH(W), .FRAME_BITS(FB)) u_dut (
    .i_sck(sck), .i_reset(reset), .i_en(en), .i_left_in(left_in), .i_right_in(right_in),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .o_ws(ws), .o_sd(sd),
    .o_frame_start(frame_start), .o_underrun(underrun)
  );

  i2s_tx_master u_dut_def (
    .i_sck(sck), .i_reset(b_reset), .i_en(b_en), .i_left_in(b_left), .i_right_in(b_right),
    .i_in_valid(b_valid), .o_in_ready(b_ready), .o_ws(b_ws), .o_sd(b_sd),
    .o_frame_start(b_fs), .o_underrun(b_und)
  );

  typedef struct { logic [W-1:0] l; logic [W-1:0] r; logic und; } frame_t;
  typedef struct { logic [W-1:0] l; logic [W-1:0] r; } pair_t;

  frame_t exp_q[$];
  pair_t  ref_buf[$];
  bit     ref_run;
  int     ref_cnt;
  bit     mon_kill;
  bit     mon_on;
  bit     exp_ready = 1'b1;
  int     n_assert = 0;
  int     n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model evaluated at each falling edge with the inputs the DUT sees.
  task automatic model_edge();
    bit     accept, load;
    frame_t f;
    pair_t  p;
    if (reset) begin
      ref_buf.delete();
      exp_q.delete();
      ref_run  = 1'b0;
      ref_cnt  = 0;
      mon_kill = 1'b1;
    end else begin
      accept = in_valid && (ref_buf.size() == 0);
      load   = en && (!ref_run || ref_cnt == LAST);
      if (ref_run) begin
        if (ref_cnt == LAST) begin
          ref_cnt = 0;
          ref_run = en;
        end else begin
          ref_cnt++;
        end
      end else begin
        ref_run = en;
      end
      if (load) begin
        if (ref_buf.size() > 0) begin
          p = ref_buf.pop_front();
          f.l = p.l; f.r = p.r; f.und = 1'b0;
        end else begin
          f.l = '0; f.r = '0; f.und = 1'b1;
        end
        exp_q.push_back(f);
      end
      if (accept) begin
        p.l = left_in; p.r = right_in;
        ref_buf.push_back(p);
      end
    end
    exp_ready = (ref_buf.size() == 0);
  endtask

  task automatic step();
    @(negedge sck);
    model_edge();
    #1;
  endtask

  initial begin : monitor
    int           idx;
    int           k;
    frame_t       cur;
    logic [W-1:0] ch;
    logic         e_sd, e_ws, e_und;
    idx = -1;
    cur.l = '0; cur.r = '0; cur.und = 1'b0;
    forever begin
      @(posedge sck);
      if (!mon_on) continue;
      if (mon_kill) begin
        idx = -1;
        mon_kill = 1'b0;
      end
      if (idx >= 0) begin
        idx++;
        if (idx == 2 * FB) idx = -1;
      end
      chk("frame_start", 32'(frame_start), 32'(exp_q.size() != 0));
      if (frame_start) begin
        idx = 0;
        if (exp_q.size() != 0) cur = exp_q.pop_front();
        else begin cur.l = '0; cur.r = '0; cur.und = 1'b0; end
      end else if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end
      e_sd = 1'b0; e_ws = 1'b0; e_und = 1'b0;
      if (idx >= 0) begin
        ch = (idx < FB) ? cur.l : cur.r;
        k  = idx % FB;
        if (k < W) e_sd = ch[W-1-k];
        e_ws  = (idx >= FB - 1) && (idx <= 2 * FB - 2);
        e_und = (idx == 0) && cur.und;
      end
      chk("sd", 32'(sd), 32'(e_sd));
      chk("ws", 32'(ws), 32'(e_ws));
      chk("underrun", 32'(underrun), 32'(e_und));
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
    end
  end

  task automatic drive_a();
    bit acc;
    reset = 1'b1; en = 1'b0; in_valid = 1'b0; left_in = '0; right_in = '0;
    step(); step();
    mon_on = 1'b1;
    reset = 1'b0;
    repeat (20) step();
    // Directed pair, en dropped mid-frame: frame must still complete then go idle.
    in_valid = 1'b1; left_in = 8'hA5; right_in = 8'h3C;
    step();
    in_valid = 1'b0; en = 1'b1;
    step();
    repeat (5) step();
    en = 1'b0;
    repeat (2 * FB + 4) step();
    // No data at all: underrun frames.
    en = 1'b1;
    repeat (6 * FB) step();
    en = 1'b0;
    repeat (2 * FB + 2) step();
    // Continuous stream of three pairs.
    for (int i = 0; i < 3; i++) begin
      left_in = W'($urandom); right_in = W'($urandom); in_valid = 1'b1;
      for (int t = 0; t < 4 * FB; t++) begin
        acc = (ref_buf.size() == 0);
        step();
        if (acc) break;
      end
      en = 1'b1;
    end
    in_valid = 1'b0;
    repeat (4 * FB) step();
    // Randomised traffic.
    acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (c % 37 == 0) en = ($urandom % 5) != 0;
      if (!in_valid || acc) begin
        in_valid = ($urandom % 3) == 0;
        left_in = W'($urandom); right_in = W'($urandom);
      end
      acc = in_valid && (ref_buf.size() == 0);
      step();
    end
    in_valid = 1'b0;
    // en dropped at cnt=5.
    en = 1'b1;
    for (int t = 0; t < 8 * FB; t++) begin
      if (ref_run && ref_cnt == 5) break;
      step();
    end
    en = 1'b0;
    repeat (2 * FB + 4) step();
    // Reset mid-frame with a pair waiting in the buffer.
    left_in = W'($urandom); right_in = W'($urandom); in_valid = 1'b1; en = 1'b1;
    step();
    in_valid = 1'b0;
    for (int t = 0; t < 8 * FB; t++) begin
      if (ref_run && ref_cnt == 6) break;
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (2 * FB + 2) step();
    en = 1'b0;
    repeat (2 * FB + 4) step();
  endtask

  task automatic drive_b();
    bit            found;
    logic [DW-1:0] lv, rv, ch;
    int            k;
    logic          e_sd;
    b_reset = 1'b1; b_en = 1'b0; b_valid = 1'b0; b_left = '0; b_right = '0;
    @(negedge sck); @(negedge sck); #1;
    b_reset = 1'b0;
    @(posedge sck);
    chk("b_reset_ready", 32'(b_ready), 32'd1);
    chk("b_reset_ws", 32'(b_ws), 32'd0);
    lv = 24'h800001; rv = DW'($urandom);
    b_left = lv; b_right = rv; b_valid = 1'b1;
    @(negedge sck); #1;
    b_valid = 1'b0; b_en = 1'b1;
    @(posedge sck);
    chk("b_ready_full", 32'(b_ready), 32'd0);
    found = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(posedge sck);
      if (b_fs) begin found = 1'b1; break; end
    end
    chk("b_frame_start_seen", 32'(found), 32'd1);
    if (found) begin
      b_en = 1'b0;
      chk("b_underrun", 32'(b_und), 32'd0);
      chk("b_ready_after_load", 32'(b_ready), 32'd1);
      for (int c = 0; c < 2 * DFB; c++) begin
        ch = (c < DFB) ? lv : rv;
        k  = c % DFB;
        e_sd = 1'b0;
        if (k < DW) e_sd = ch[DW-1-k];
        chk("b_sd", 32'(b_sd), 32'(e_sd));
        chk("b_ws", 32'(b_ws), 32'((c >= DFB - 1) && (c <= 2 * DFB - 2)));
        @(posedge sck);
      end
      chk("b_idle_fs", 32'(b_fs), 32'd0);
      chk("b_idle_sd", 32'(b_sd), 32'd0);
      chk("b_idle_ws", 32'(b_ws), 32'd0);
    end
  endtask

  initial begin
    fork
      drive_a();
      drive_b();
    join
    @(negedge sck);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
